// File: rtl/rfft_4pt_pkg.sv
// Shared constants and helpers for the four-bank radix-2 FFT compute element.
package rfft_4pt_pkg;

    localparam int DEF_ADDR_BIT = 3;
    localparam int DEF_DATA_BIT = 16;
    // Twiddles carry two integer bits (Q2.14 at 16 bits).
    localparam int FRAC_GUARD   = 2;

    typedef enum logic {
        SRC_LOAD    = 1'b0,
        SRC_COMPUTE = 1'b1
    } src_e;

    // Bank 0 occupies the most significant field of a packed address bus.
    function automatic int addr_lsb(input int bank, input int abit);
        return (3 - bank) * abit;
    endfunction

endpackage

// File: rtl/rfft_4pt_bank.sv
// One data bank: async-cleared word array, combinational read, registered read-back.
module rfft_4pt_bank
    import rfft_4pt_pkg::*;
#(
    parameter int ADDR_BIT = DEF_ADDR_BIT,
    parameter int DATA_BIT = DEF_DATA_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_BIT-1:0] raddr,
    input  logic [ADDR_BIT-1:0] waddr,
    input  logic [DATA_BIT-1:0] wdata,
    output logic [DATA_BIT-1:0] rdata,
    output logic [DATA_BIT-1:0] mem
);

    localparam int DEPTH = 1 << ADDR_BIT;

    logic [DATA_BIT-1:0] word_q [DEPTH];
    logic [DATA_BIT-1:0] word_d [DEPTH];
    logic [DATA_BIT-1:0] mem_q;
    logic [DATA_BIT-1:0] mem_d;

    // Read-back samples the pre-write contents, so an in-place update shows old data.
    always_comb begin
        word_d        = word_q;
        word_d[waddr] = wdata;
        mem_d         = word_q[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
            mem_q <= '0;
        end else begin
            word_q <= word_d;
            mem_q  <= mem_d;
        end
    end

    assign rdata = word_q[raddr];
    assign mem   = mem_q;

endmodule

// File: rtl/rfft_4pt.sv
// Four-bank in-place radix-2 compute element: crossbars, add/sub and twiddle butterflies.
module rfft_4pt
    import rfft_4pt_pkg::*;
#(
    parameter int ADDR_BIT = DEF_ADDR_BIT,
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int FRAC     = DATA_BIT - FRAC_GUARD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BIT-1:0]   in0,
    input  logic [DATA_BIT-1:0]   in1,
    input  logic [DATA_BIT-1:0]   in2,
    input  logic [DATA_BIT-1:0]   in3,
    output logic [DATA_BIT-1:0]   mem0,
    output logic [DATA_BIT-1:0]   mem1,
    output logic [DATA_BIT-1:0]   mem2,
    output logic [DATA_BIT-1:0]   mem3,
    input  logic                  m0,
    input  logic                  m11,
    input  logic [1:0]            m12,
    input  logic [1:0]            m13,
    input  logic                  m14,
    input  logic                  m21,
    input  logic                  m22,
    input  logic                  m23,
    input  logic                  m24,
    input  logic [DATA_BIT-1:0]   w_r,
    input  logic [DATA_BIT-1:0]   w_i,
    input  logic                  bypass_en,
    input  logic [4*ADDR_BIT-1:0] addr_read,
    input  logic [4*ADDR_BIT-1:0] addr_write
);

    localparam int PW = 2 * DATA_BIT;

    logic [DATA_BIT-1:0] rd      [4];
    logic [DATA_BIT-1:0] mem_rd  [4];
    logic [DATA_BIT-1:0] din     [4];
    logic [DATA_BIT-1:0] wd      [4];
    logic [DATA_BIT-1:0] wr_data [4];

    logic signed [DATA_BIT-1:0] a, b, c, d;
    logic signed [PW-1:0]       p_cwr, p_dwi, p_cwi, p_dwr;
    logic signed [PW:0]         re_full, im_full;
    logic [DATA_BIT-1:0]        ya0, ya1, yb0, yb1;

    assign din[0] = in0;
    assign din[1] = in1;
    assign din[2] = in2;
    assign din[3] = in3;

    assign mem0 = mem_rd[0];
    assign mem1 = mem_rd[1];
    assign mem2 = mem_rd[2];
    assign mem3 = mem_rd[3];

    for (genvar k = 0; k < 4; k++) begin : g_bank
        rfft_4pt_bank #(
            .ADDR_BIT(ADDR_BIT),
            .DATA_BIT(DATA_BIT)
        ) u_bank (
            .clk  (clk),
            .rst  (rst),
            .raddr(addr_read[addr_lsb(k, ADDR_BIT) +: ADDR_BIT]),
            .waddr(addr_write[addr_lsb(k, ADDR_BIT) +: ADDR_BIT]),
            .wdata(wr_data[k]),
            .rdata(rd[k]),
            .mem  (mem_rd[k])
        );
    end

    always_comb begin
        a = m11 ? rd[1] : rd[0];
        b = rd[m12];
        c = rd[m13];
        d = m14 ? rd[3] : rd[2];

        ya0 = a + b;
        ya1 = a - b;

        p_cwr = PW'(c) * PW'($signed(w_r));
        p_dwi = PW'(d) * PW'($signed(w_i));
        p_cwi = PW'(c) * PW'($signed(w_i));
        p_dwr = PW'(d) * PW'($signed(w_r));

        // One guard bit keeps the sum exact before the truncating shift and wrap.
        re_full = {p_cwr[PW-1], p_cwr} - {p_dwi[PW-1], p_dwi};
        im_full = {p_cwi[PW-1], p_cwi} + {p_dwr[PW-1], p_dwr};

        if (bypass_en) begin
            yb0 = c;
            yb1 = d;
        end else begin
            yb0 = DATA_BIT'(re_full >>> FRAC);
            yb1 = DATA_BIT'(im_full >>> FRAC);
        end

        wd[0] = m21 ? yb0 : ya0;
        wd[1] = m22 ? yb1 : ya1;
        wd[2] = m23 ? ya0 : yb0;
        wd[3] = m24 ? ya1 : yb1;

        for (int k = 0; k < 4; k++) begin
            unique case (src_e'(m0))
                SRC_LOAD:    wr_data[k] = din[k];
                SRC_COMPUTE: wr_data[k] = wd[k];
                default:     wr_data[k] = din[k];
            endcase
        end
    end

endmodule

// File: tb/tb_rfft_4pt.sv
// Scoreboard bench for rfft_4pt: a spec-level bank model predicts every read-back.
module tb_rfft_4pt;

    localparam int A = 3;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] in_v [4];
    logic [W-1:0] mem0, mem1, mem2, mem3;
    logic m0, m11, m14, m21, m22, m23, m24, bypass_en;
    logic [1:0] m12, m13;
    logic [W-1:0] w_r, w_i;
    logic [A-1:0] ra [4];
    logic [A-1:0] wa [4];
    logic [4*A-1:0] addr_read, addr_write;

    typedef struct {
        logic [4*W-1:0] m;
        string          nm;
    } exp_t;

    exp_t         sb [$];
    logic [W-1:0] model [4][8];
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    assign addr_read  = {ra[0], ra[1], ra[2], ra[3]};
    assign addr_write = {wa[0], wa[1], wa[2], wa[3]};

    rfft_4pt dut (
        .clk       (clk),
        .rst       (rst),
        .in0       (in_v[0]),
        .in1       (in_v[1]),
        .in2       (in_v[2]),
        .in3       (in_v[3]),
        .mem0      (mem0),
        .mem1      (mem1),
        .mem2      (mem2),
        .mem3      (mem3),
        .m0        (m0),
        .m11       (m11),
        .m12       (m12),
        .m13       (m13),
        .m14       (m14),
        .m21       (m21),
        .m22       (m22),
        .m23       (m23),
        .m24       (m24),
        .w_r       (w_r),
        .w_i       (w_i),
        .bypass_en (bypass_en),
        .addr_read (addr_read),
        .addr_write(addr_write)
    );

    task automatic clear_model();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 8; i++)
                model[k][i] = '0;
    endtask

    task automatic set_addr(input logic [A-1:0] r, input logic [A-1:0] w);
        for (int k = 0; k < 4; k++) begin
            ra[k] = r;
            wa[k] = w;
        end
    endtask

    task automatic set_ctl(input logic s0, input logic s11, input logic [1:0] s12,
                           input logic [1:0] s13, input logic s14, input logic byp,
                           input logic [3:0] s2x);
        m0 = s0; m11 = s11; m12 = s12; m13 = s13; m14 = s14; bypass_en = byp;
        {m21, m22, m23, m24} = s2x;
    endtask

    task automatic set_in(input logic [W-1:0] v0, input logic [W-1:0] v1,
                          input logic [W-1:0] v2, input logic [W-1:0] v3);
        in_v[0] = v0; in_v[1] = v1; in_v[2] = v2; in_v[3] = v3;
    endtask

    // Predict this cycle's read-back and writes from the spec, then clock and compare.
    task automatic step(input string nm);
        logic [W-1:0] r [4];
        logic [W-1:0] wdv [4];
        logic signed [W-1:0] a, b, c, d;
        logic [W-1:0] ya0, ya1, yb0, yb1;
        longint re, im;
        exp_t e;
        for (int k = 0; k < 4; k++) r[k] = model[k][ra[k]];
        e.m  = {r[0], r[1], r[2], r[3]};
        e.nm = nm;
        sb.push_back(e);
        a = m11 ? r[1] : r[0];
        b = r[m12];
        c = r[m13];
        d = m14 ? r[3] : r[2];
        ya0 = a + b;
        ya1 = a - b;
        if (bypass_en) begin
            yb0 = c;
            yb1 = d;
        end else begin
            re  = longint'(c) * longint'($signed(w_r)) - longint'(d) * longint'($signed(w_i));
            im  = longint'(c) * longint'($signed(w_i)) + longint'(d) * longint'($signed(w_r));
            yb0 = 16'(re >>> 14);
            yb1 = 16'(im >>> 14);
        end
        wdv[0] = m21 ? yb0 : ya0;
        wdv[1] = m22 ? yb1 : ya1;
        wdv[2] = m23 ? ya0 : yb0;
        wdv[3] = m24 ? ya1 : yb1;
        for (int k = 0; k < 4; k++) model[k][wa[k]] = m0 ? wdv[k] : in_v[k];
        @(posedge clk);
        #1;
        e = sb.pop_front();
        total++;
        if ({mem0, mem1, mem2, mem3} !== e.m) begin
            bad++;
            $display("FAIL %s: mem=%h_%h_%h_%h required %h", e.nm, mem0, mem1, mem2, mem3, e.m);
        end
    endtask

    task automatic check_const(input string nm, input logic [4*W-1:0] want);
        total++;
        if ({mem0, mem1, mem2, mem3} !== want) begin
            bad++;
            $display("FAIL %s: mem=%h_%h_%h_%h required %h", nm, mem0, mem1, mem2, mem3, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        set_addr(3'd0, 3'd0);
        w_r = '0; w_i = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_const("reset_mem", 64'h0);
        rst = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            set_addr(3'(i), 3'(i));
            step("reset_sweep");
        end
    endtask

    task automatic test_load();
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'd1, 16'd2, 16'd3, 16'd4);
        set_addr(3'd0, 3'd5);
        step("load_wr");
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        set_addr(3'd5, 3'd7);
        step("load_rd");
        check_const("load_value", 64'h0001_0002_0003_0004);
    endtask

    task automatic test_bypass();
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'd1, 16'd2, 16'd3, 16'd4);
        set_addr(3'd7, 3'd0);
        step("bypass_load");
        set_ctl(1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 1'b1, 4'h0);
        set_addr(3'd0, 3'd0);
        step("bypass_compute");
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        set_addr(3'd0, 3'd7);
        step("bypass_rd");
        check_const("bypass_value", 64'h0004_FFFE_0002_0004);
    endtask

    task automatic test_twiddle();
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h0, 16'h4000, 16'h0, 16'h0);
        set_addr(3'd7, 3'd1);
        step("tw_load");
        set_ctl(1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 4'h0);
        w_r = 16'h2000; w_i = 16'h4000;
        set_addr(3'd1, 3'd1);
        step("tw_compute");
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        set_addr(3'd1, 3'd7);
        step("tw_rd");
        check_const("tw_value", 64'h0000_0000_2000_4000);
    endtask

    task automatic test_wrap();
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h7FFF, 16'h0, 16'h1, 16'h0);
        set_addr(3'd7, 3'd2);
        step("wrap_load");
        set_ctl(1'b1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, 4'h0);
        set_addr(3'd2, 3'd2);
        step("wrap_compute");
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        set_addr(3'd2, 3'd7);
        step("wrap_rd");
        check_const("wrap_value", 64'h8000_7FFE_0000_0001);
    endtask

    task automatic test_back_to_back();
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'd10, 16'd20, 16'd30, 16'd40);
        set_addr(3'd7, 3'd3);
        step("b2b_load");
        set_ctl(1'b1, 1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 4'h0);
        set_addr(3'd3, 3'd3);
        step("b2b_first");
        check_const("b2b_first_prewrite", 64'h000A_0014_001E_0028);
        step("b2b_second");
        check_const("b2b_second_prewrite", 64'h001E_000A_001E_0028);
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        set_addr(3'd3, 3'd7);
        step("b2b_rd");
        check_const("b2b_value", 64'h0028_FFEC_001E_0028);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            set_ctl(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                    1'($urandom_range(0, 3) == 0), 4'($urandom));
            set_in(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            w_r = 16'($urandom);
            w_i = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                ra[k] = 3'($urandom);
                wa[k] = 3'($urandom);
            end
            step("random");
        end
    endtask

    task automatic test_reset_mid();
        set_ctl(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 4'h0);
        set_in(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        set_addr(3'd4, 3'd4);
        step("mid_load");
        step("mid_rd");
        check_const("mid_rd_value", 64'hAAAA_BBBB_CCCC_DDDD);
        #3;
        rst = 1'b1;
        #1;
        check_const("mid_async_clear", 64'h0);
        @(posedge clk);
        #1;
        check_const("mid_held", 64'h0);
        clear_model();
        rst = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 8; i++) begin
            set_addr(3'(i), 3'(i));
            step("mid_sweep");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bypass();
        test_twiddle();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: left=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
